// File: rtl/pic_pkg.sv
// Shared constants for the synchronous programmable interrupt controller core.
// Holds the FSM state codes, the OCW2 command encodings and the field positions
// of the ICW1/ICW4/OCW3 control bytes.
package pic_pkg;

  // Interrupt ids are at most 3 bits wide (up to 8 request lines).
  localparam int ID_W = 3;

  // Initialisation / operating states.
  localparam logic [1:0] S_ICW1  = 2'd0;
  localparam logic [1:0] S_ICW2  = 2'd1;
  localparam logic [1:0] S_ICW4  = 2'd2;
  localparam logic [1:0] S_READY = 2'd3;

  // OCW2 commands, din[7:5].
  localparam logic [2:0] OCW2_CLR_RAEOI = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI    = 3'b001;
  localparam logic [2:0] OCW2_NOP       = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI    = 3'b011;
  localparam logic [2:0] OCW2_SET_RAEOI = 3'b100;
  localparam logic [2:0] OCW2_NS_ROT    = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO  = 3'b110;
  localparam logic [2:0] OCW2_SP_ROT    = 3'b111;

  // Control word selector, din[4:3] when a0 = 0 and din[4] = 0.
  localparam logic [1:0] OCW_KIND_OCW2 = 2'b00;
  localparam logic [1:0] OCW_KIND_OCW3 = 2'b01;

  // Bit positions inside the control bytes.
  localparam int ICW1_SEL_BIT  = 4;
  localparam int ICW1_LTIM_BIT = 3;
  localparam int ICW1_IC4_BIT  = 0;
  localparam int ICW4_AEOI_BIT = 1;
  localparam int OCW3_RR_BIT   = 1;
  localparam int OCW3_RIS_BIT  = 0;

endpackage

// File: rtl/pic_prio_rotate.sv
// Circular priority resolver: finds the highest-priority set bit of req, where
// priority starts at lowest+1 and wraps. Purely combinational. rank is one-hot at
// the winner's position in that order (bit 0 = highest), so ranks compare numerically.
module pic_prio_rotate
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [ID_W-1:0]    lowest,
  output logic               valid,
  output logic [ID_W-1:0]    id,
  output logic [NUM_IRQ-1:0] rank
);

  int start;
  int idx;

  // Scan from lowest priority to highest so the highest-priority hit is the last write.
  always_comb begin
    start = (int'(lowest) >= NUM_IRQ - 1) ? 0 : int'(lowest) + 1;
    idx   = 0;
    valid = 1'b0;
    id    = '0;
    rank  = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      idx = start + k;
      if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
      if (req[idx]) begin
        valid = 1'b1;
        id    = ID_W'(idx);
        rank  = NUM_IRQ'(1) << k;
      end
    end
  end

endmodule

// File: rtl/pic_core_sync.sv
// Single-clock 8259-style interrupt controller core: IRR/ISR/IMR, ICW/OCW decode,
// fixed or rotating priority and the two-pulse INTA vector handshake.
// Outputs are registered; reads and vectors appear the cycle after their strobe.
module pic_core_sync
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int DW      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic               a0,
  input  logic [DW-1:0]      din,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               inta,
  output logic               int_o,
  output logic [DW-1:0]      dout,
  output logic               dout_oe
);

  localparam logic [ID_W-1:0]    ID_LAST = ID_W'(NUM_IRQ - 1);
  localparam logic [NUM_IRQ-1:0] ONE     = NUM_IRQ'(1);

  logic [1:0]         state, state_n;
  logic               ic4, ic4_n;
  logic               ltim, ltim_n;
  logic               aeoi, aeoi_n;
  logic               rot_aeoi, rot_aeoi_n;
  logic               rd_isr, rd_isr_n;
  logic [4:0]         base, base_n;
  logic [ID_W-1:0]    lowest, lowest_n;
  logic [NUM_IRQ-1:0] irr, irr_n;
  logic [NUM_IRQ-1:0] isr, isr_n;
  logic [NUM_IRQ-1:0] imr, imr_n;
  logic [NUM_IRQ-1:0] irq_q;
  logic               ack_pend, ack_pend_n;
  logic               ack_spur, ack_spur_n;
  logic [ID_W-1:0]    ack_id, ack_id_n;
  logic               int_n;
  logic [DW-1:0]      dout_n;
  logic               dout_oe_n;
  logic               icw1_wr;
  logic [NUM_IRQ-1:0] ack_clr;

  logic               cand_vld, isr_vld;
  logic [ID_W-1:0]    cand_id, isr_id;
  logic [NUM_IRQ-1:0] cand_rank, isr_rank;

  // Highest unmasked pending request.
  pic_prio_rotate #(.NUM_IRQ(NUM_IRQ)) u_cand (
    .req    (irr & ~imr),
    .lowest (lowest),
    .valid  (cand_vld),
    .id     (cand_id),
    .rank   (cand_rank)
  );

  // Highest in-service level, used for nesting and non-specific EOI.
  pic_prio_rotate #(.NUM_IRQ(NUM_IRQ)) u_isr (
    .req    (isr),
    .lowest (lowest),
    .valid  (isr_vld),
    .id     (isr_id),
    .rank   (isr_rank)
  );

  // Next-state: register read, then the CPU write, then the acknowledge, then request capture.
  always_comb begin
    state_n    = state;
    ic4_n      = ic4;
    ltim_n     = ltim;
    aeoi_n     = aeoi;
    rot_aeoi_n = rot_aeoi;
    rd_isr_n   = rd_isr;
    base_n     = base;
    lowest_n   = lowest;
    irr_n      = irr;
    isr_n      = isr;
    imr_n      = imr;
    ack_pend_n = ack_pend;
    ack_spur_n = ack_spur;
    ack_id_n   = ack_id;
    ack_clr    = '0;
    dout_n     = dout;
    dout_oe_n  = 1'b0;
    icw1_wr    = wr_en && !a0 && din[ICW1_SEL_BIT];

    // A candidate interrupts only if it outranks everything already in service.
    int_n = (state == S_READY) && cand_vld && (!isr_vld || (cand_rank < isr_rank));

    if (rd_en) begin
      dout_oe_n = 1'b1;
      if (a0)          dout_n = DW'(imr);
      else if (rd_isr) dout_n = DW'(isr);
      else             dout_n = DW'(irr);
    end

    if (icw1_wr) begin
      ic4_n      = din[ICW1_IC4_BIT];
      ltim_n     = din[ICW1_LTIM_BIT];
      irr_n      = '0;
      isr_n      = '0;
      imr_n      = '0;
      ack_pend_n = 1'b0;
      ack_spur_n = 1'b0;
      lowest_n   = ID_LAST;
      rd_isr_n   = 1'b0;
      aeoi_n     = 1'b0;
      rot_aeoi_n = 1'b0;
      state_n    = S_ICW2;
      int_n      = 1'b0;
    end else if (wr_en && a0) begin
      case (state)
        S_ICW2: begin
          base_n  = din[7:3];
          state_n = ic4 ? S_ICW4 : S_READY;
        end
        S_ICW4: begin
          aeoi_n  = din[ICW4_AEOI_BIT];
          state_n = S_READY;
        end
        S_READY: imr_n = din[NUM_IRQ-1:0];
        default: ;
      endcase
    end else if (wr_en && (state == S_READY)) begin
      if (din[4:3] == OCW_KIND_OCW2) begin
        case (din[7:5])
          OCW2_NS_EOI:    if (isr_vld) isr_n = isr_n & ~(ONE << isr_id);
          OCW2_SP_EOI:    isr_n = isr_n & ~(ONE << din[2:0]);
          OCW2_NS_ROT: begin
            if (isr_vld) begin
              isr_n    = isr_n & ~(ONE << isr_id);
              lowest_n = isr_id;
            end
          end
          OCW2_SP_ROT: begin
            isr_n    = isr_n & ~(ONE << din[2:0]);
            lowest_n = din[2:0];
          end
          OCW2_SET_RAEOI: rot_aeoi_n = 1'b1;
          OCW2_CLR_RAEOI: rot_aeoi_n = 1'b0;
          OCW2_SET_PRIO:  lowest_n   = din[2:0];
          OCW2_NOP:       ;
          default:        ;
        endcase
      end else if (din[4:3] == OCW_KIND_OCW3) begin
        if (din[OCW3_RR_BIT]) rd_isr_n = din[OCW3_RIS_BIT];
      end
    end

    // ICW1 restarts the controller, so a concurrent inta is dropped.
    if (inta && !icw1_wr) begin
      if (!ack_pend) begin
        ack_pend_n = 1'b1;
        int_n      = 1'b0;
        if (cand_vld) begin
          ack_id_n   = cand_id;
          ack_spur_n = 1'b0;
          isr_n      = isr_n | (ONE << cand_id);
          ack_clr    = ONE << cand_id;
        end else begin
          ack_id_n   = ID_LAST;
          ack_spur_n = 1'b1;
        end
      end else begin
        ack_pend_n = 1'b0;
        dout_oe_n  = 1'b1;
        dout_n     = DW'({base_n, ack_id});
        if (aeoi_n && !ack_spur) begin
          isr_n = isr_n & ~(ONE << ack_id);
          if (rot_aeoi_n) lowest_n = ack_id;
        end
      end
    end

    // A new edge beats the acknowledge clear of the same bit.
    if (!icw1_wr) begin
      if (ltim) irr_n = irq & ~ack_clr;
      else      irr_n = (irr_n & ~ack_clr) | (irq & ~irq_q);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_ICW1;
      ic4      <= 1'b0;
      ltim     <= 1'b0;
      aeoi     <= 1'b0;
      rot_aeoi <= 1'b0;
      rd_isr   <= 1'b0;
      base     <= '0;
      lowest   <= ID_LAST;
      irr      <= '0;
      isr      <= '0;
      imr      <= '1;
      irq_q    <= '0;
      ack_pend <= 1'b0;
      ack_spur <= 1'b0;
      ack_id   <= '0;
      int_o    <= 1'b0;
      dout     <= '0;
      dout_oe  <= 1'b0;
    end else begin
      state    <= state_n;
      ic4      <= ic4_n;
      ltim     <= ltim_n;
      aeoi     <= aeoi_n;
      rot_aeoi <= rot_aeoi_n;
      rd_isr   <= rd_isr_n;
      base     <= base_n;
      lowest   <= lowest_n;
      irr      <= irr_n;
      isr      <= isr_n;
      imr      <= imr_n;
      irq_q    <= irq;
      ack_pend <= ack_pend_n;
      ack_spur <= ack_spur_n;
      ack_id   <= ack_id_n;
      int_o    <= int_n;
      dout     <= dout_n;
      dout_oe  <= dout_oe_n;
    end
  end

endmodule

// File: tb/tb_pic_core_sync.sv
// Bench for pic_core_sync: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the controller kept in the bench.
module tb_pic_core_sync;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0, a0 = 1'b0, inta = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] irq = 8'h00;
  logic       int_o, dout_oe;
  logic [7:0] dout;

  int n_vec = 0;
  int n_err = 0;
  bit [7:0] cur_irq = 8'h00;

  pic_core_sync #(.NUM_IRQ(N), .DW(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .a0(a0), .din(din),
    .irq(irq), .inta(inta), .int_o(int_o), .dout(dout), .dout_oe(dout_oe)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int       m_state, m_base, m_low, m_id, m_dout;
  bit       m_ic4, m_ltim, m_aeoi, m_rot, m_rdisr, m_pend, m_spur, m_int, m_oe;
  bit [7:0] m_irr, m_isr, m_imr, m_irq_q;

  function automatic int start_of(int low);
    return (low >= N - 1) ? 0 : low + 1;
  endfunction

  // Highest-priority set bit of v under circular order, -1 if none.
  function automatic int best(bit [7:0] v, int low);
    for (int k = 0; k < N; k++) begin
      int i = (start_of(low) + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int rank_of(int i, int low);
    return (i - start_of(low) + N) % N;
  endfunction

  task automatic model_reset();
    m_state = 0; m_base = 0; m_low = N - 1; m_id = 0; m_dout = 0;
    m_ic4 = 0; m_ltim = 0; m_aeoi = 0; m_rot = 0; m_rdisr = 0; m_pend = 0; m_spur = 0;
    m_int = 0; m_oe = 0;
    m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_irq_q = 0;
  endtask

  task automatic model_step(input bit wr, input bit rd, input bit a, input bit [7:0] d,
                            input bit [7:0] q, input bit ia);
    int c, t, lvl, ndout;
    bit nint, noe, icw1;
    bit [7:0] clr;
    c = best(m_irr & ~m_imr, m_low);
    t = best(m_isr, m_low);
    nint = (m_state == 3) && (c >= 0) && (t < 0 || rank_of(c, m_low) < rank_of(t, m_low));
    noe = 0; ndout = m_dout; clr = 0; lvl = int'(d[2:0]);
    icw1 = wr && !a && d[4];
    if (rd) begin
      noe = 1;
      ndout = a ? int'(m_imr) : (m_rdisr ? int'(m_isr) : int'(m_irr));
    end
    if (icw1) begin
      m_ic4 = d[0]; m_ltim = d[3]; m_irr = 0; m_isr = 0; m_pend = 0; m_imr = 0;
      m_low = N - 1; m_rdisr = 0; m_aeoi = 0; m_rot = 0; m_state = 1; nint = 0;
    end else if (wr && a) begin
      case (m_state)
        1: begin m_base = int'(d[7:3]); m_state = m_ic4 ? 2 : 3; end
        2: begin m_aeoi = d[1]; m_state = 3; end
        3: m_imr = d;
        default: ;
      endcase
    end else if (wr && m_state == 3 && !d[3]) begin
      case (d[7:5])
        3'd1: if (t >= 0) m_isr[t] = 0;
        3'd3: m_isr[lvl] = 0;
        3'd5: if (t >= 0) begin m_isr[t] = 0; m_low = t; end
        3'd7: begin m_isr[lvl] = 0; m_low = lvl; end
        3'd4: m_rot = 1;
        3'd0: m_rot = 0;
        3'd6: m_low = lvl;
        default: ;
      endcase
    end else if (wr && m_state == 3) begin
      if (d[1]) m_rdisr = d[0];
    end
    if (ia && !icw1) begin
      if (!m_pend) begin
        m_pend = 1; nint = 0;
        if (c >= 0) begin m_id = c; m_spur = 0; m_isr[c] = 1; clr[c] = 1; end
        else begin m_id = N - 1; m_spur = 1; end
      end else begin
        m_pend = 0; noe = 1; ndout = m_base * 8 + m_id;
        if (m_aeoi && !m_spur) begin
          m_isr[m_id] = 0;
          if (m_rot) m_low = m_id;
        end
      end
    end
    if (!icw1) m_irr = m_ltim ? (q & ~clr) : ((m_irr & ~clr) | (q & ~m_irq_q));
    m_irq_q = q; m_int = nint; m_oe = noe; m_dout = ndout;
  endtask

  // ---------------- checking and stimulus helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit wr, input bit rd, input bit a, input bit [7:0] d, input bit ia);
    wr_en = wr; rd_en = rd; a0 = a; din = d; irq = cur_irq; inta = ia;
    model_step(wr, rd, a, d, cur_irq, ia);
    @(posedge clk); #1;
    chk("int_o", int_o, m_int);
    chk("dout_oe", dout_oe, m_oe);
    if (m_oe) chk("dout", dout, m_dout);
    wr_en = 0; rd_en = 0; inta = 0; din = 8'h00;
  endtask

  task automatic wr(input bit a, input bit [7:0] d); cyc(1, 0, a, d, 0); endtask
  task automatic rdr(input bit a); cyc(0, 1, a, 8'h00, 0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 0); endtask
  task automatic ack(); cyc(0, 0, 0, 8'h00, 1); cyc(0, 0, 0, 8'h00, 1); endtask
  task automatic pulse(input bit [7:0] m); cur_irq = m; idle(1); cur_irq = 0; endtask

  task automatic init(input bit [7:0] i1, input bit [7:0] i2, input bit [7:0] i4, input bit [7:0] o1);
    wr(0, i1); wr(1, i2);
    if (i1[0]) wr(1, i4);
    wr(1, o1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_int_o", int_o, 0);
    chk("rst_dout_oe", dout_oe, 0);
    chk("rst_dout", dout, 0);
    rst = 0;
    rdr(1);
    chk("rst_imr", dout, 8'hFF);

    // Init and fixed priority: irq3 beats irq5.
    init(8'h13, 8'h40, 8'h00, 8'h00);
    pulse(8'h28);
    chk("lat_int_low", int_o, 0);
    idle(1);
    chk("lat_int_high", int_o, 1);
    ack();
    chk("fixed_vec", dout, 8'h43);
    wr(0, 8'h0B); rdr(0);
    chk("fixed_isr", dout, 8'h08);

    // Nesting and non-specific EOI.
    pulse(8'h20); idle(2);
    chk("nest_block", int_o, 0);
    pulse(8'h02); idle(1);
    chk("nest_raise", int_o, 1);
    ack();
    chk("nest_vec", dout, 8'h41);
    wr(0, 8'h20); rdr(0);
    chk("nseoi_isr", dout, 8'h08);

    // AEOI with rotate-in-AEOI.
    init(8'h13, 8'h40, 8'h02, 8'h00);
    wr(0, 8'h80);
    pulse(8'h04); idle(1);
    ack();
    chk("aeoi_vec", dout, 8'h42);
    wr(0, 8'h0B); rdr(0);
    chk("aeoi_isr", dout, 8'h00);
    pulse(8'h0A); idle(1);
    ack();
    chk("rot_vec", dout, 8'h43);

    // Masking, read-back, specific EOI, spurious ack.
    init(8'h13, 8'h40, 8'h00, 8'h00);
    wr(1, 8'hF7);
    pulse(8'hFF); idle(1);
    ack();
    chk("mask_vec", dout, 8'h43);
    ack();
    chk("spur_vec", dout, 8'h47);
    wr(0, 8'h0B); rdr(0);
    chk("mask_isr", dout, 8'h08);
    wr(0, 8'h63); rdr(0);
    chk("speoi_isr", dout, 8'h00);

    // Spurious ack with nothing pending leaves ISR alone.
    init(8'h13, 8'h40, 8'h00, 8'h00);
    ack();
    chk("spur0_vec", dout, 8'h47);
    wr(0, 8'h0B); rdr(0);
    chk("spur0_isr", dout, 8'h00);

    // Level mode: held request re-asserts after EOI.
    init(8'h1B, 8'h40, 8'h00, 8'h00);
    cur_irq = 8'h10; idle(2);
    chk("lvl_int", int_o, 1);
    ack();
    chk("lvl_vec", dout, 8'h44);
    idle(2);
    chk("lvl_held_low", int_o, 0);
    wr(0, 8'h20); idle(1);
    chk("lvl_reassert", int_o, 1);
    cur_irq = 0; idle(2);

    // Reset between the two inta pulses.
    init(8'h13, 8'h40, 8'h00, 8'h00);
    pulse(8'h20); idle(1);
    cyc(0, 0, 0, 8'h00, 1);
    pulse(8'h01); idle(1);
    chk("pre_rst_int", int_o, 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_int_o", int_o, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_oe", dout_oe, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;

    // Re-init during a pending ack drops the vector.
    init(8'h13, 8'h40, 8'h00, 8'h00);
    pulse(8'h08); idle(1);
    cyc(0, 0, 0, 8'h00, 1);
    init(8'h13, 8'h40, 8'h00, 8'h00);
    cyc(0, 0, 0, 8'h00, 1);
    chk("reinit_no_vec", dout_oe, 0);
    cyc(1, 0, 0, 8'h13, 1);
    chk("icw1_inta_no_vec", dout_oe, 0);
    wr(1, 8'h48); wr(1, 8'h00); wr(1, 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      int r;
      if (i % 500 == 0) begin
        bit [7:0] i1;
        i1 = 8'h10 | (8'($urandom_range(0, 1)) << 3) | 8'($urandom_range(0, 1));
        init(i1, 8'($urandom) & 8'hF8, 8'($urandom) & 8'h02, 8'($urandom & $urandom));
      end
      cur_irq = cur_irq ^ 8'($urandom & $urandom & $urandom);
      r = $urandom_range(0, 99);
      if (r < 10)      wr(1, 8'($urandom & $urandom));
      else if (r < 18) wr(0, {3'($urandom), 2'b00, 3'($urandom)});
      else if (r < 22) wr(0, {3'($urandom), 2'b01, 3'($urandom)});
      else if (r < 30) rdr(1'($urandom));
      else if (r < 50) cyc(0, 0, 0, 8'h00, 1);
      else if (r < 55) cyc(1, 0, 0, {3'($urandom), 2'b00, 3'($urandom)}, 1);
      else             idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
